led_pattern_gen: RTL and testbench

//   Parametrised LED pattern generator: successor to the fixed blink/count timer.
//   - Built-in prescaler derives a tick from CLK_HZ/TICK_HZ.
//   - Tick drives one of four run-time selectable patterns on NUM_LEDS outputs:

---
 rtl/led_pattern_gen.sv | 145 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - tick-driven LED pattern generator (binary, walk, gray, breathe)
module led_pattern_gen #(
  parameter int NUM_LEDS   = 6,
  parameter int CLK_HZ     = 27000000,
  parameter int TICK_HZ    = 2,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int PWM_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic                tick_out,
  output logic [NUM_LEDS-1:0] led_output
);

  localparam int COUNT_MAX = CLK_HZ / TICK_HZ - 1;
  localparam int PW        = (COUNT_MAX > 0) ? $clog2(COUNT_MAX + 1) : 1;

  localparam logic [PW-1:0]       PRE_LAST = PW'(COUNT_MAX);
  localparam logic [PW-1:0]       PRE_ONE  = PW'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LEDS_OFF = {NUM_LEDS{ACTIVE_LOW}};

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [PW-1:0]       prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [1:0]          mode_q,  mode_q_n;
  logic [NUM_LEDS-1:0] cnt,     cnt_n;
  logic [NUM_LEDS-1:0] walk,    walk_n;
  dir_t                dir,     dir_n;
  logic [3:0]          lvl,     lvl_n;
  dir_t                lvl_dir, lvl_dir_n;
  logic [PWM_BITS-1:0] duty;
  logic [NUM_LEDS-1:0] pattern;

  // Pattern state only moves on a step; a mode change spends its step on reinitialisation.
  always_comb begin
    mode_q_n  = mode_q;
    cnt_n     = cnt;
    walk_n    = walk;
    dir_n     = dir;
    lvl_n     = lvl;
    lvl_dir_n = lvl_dir;
    if (enable && tick_out) begin
      if (mode != mode_q) begin
        mode_q_n  = mode;
        cnt_n     = '0;
        walk_n    = LED_ONE;
        dir_n     = UP;
        lvl_n     = 4'd0;
        lvl_dir_n = UP;
      end else begin
        case (mode_q)
          2'd1: begin
            if (NUM_LEDS > 1) begin
              if (dir == UP) begin
                if (walk[NUM_LEDS-1]) begin
                  dir_n  = DOWN;
                  walk_n = walk >> 1;
                end else begin
                  walk_n = walk << 1;
                end
              end else begin
                if (walk[0]) begin
                  dir_n  = UP;
                  walk_n = walk << 1;
                end else begin
                  walk_n = walk >> 1;
                end
              end
            end
          end
          2'd3: begin
            if (lvl_dir == UP) begin
              if (lvl == 4'd15) begin
                lvl_dir_n = DOWN;
                lvl_n     = 4'd14;
              end else begin
                lvl_n = lvl + 4'd1;
              end
            end else begin
              if (lvl == 4'd0) begin
                lvl_dir_n = UP;
                lvl_n     = 4'd1;
              end else begin
                lvl_n = lvl - 4'd1;
              end
            end
          end
          default: cnt_n = cnt + LED_ONE;
        endcase
      end
    end
  end

  always_comb begin
    duty    = PWM_BITS'(lvl) << (PWM_BITS - 4);
    pattern = cnt;
    case (mode_q)
      2'd1:    pattern = walk;
      2'd2:    pattern = cnt ^ (cnt >> 1);
      2'd3:    pattern = {NUM_LEDS{pwm_cnt < duty}};
      default: pattern = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler  <= '0;
      tick_out   <= 1'b0;
      pwm_cnt    <= '0;
      mode_q     <= 2'd0;
      cnt        <= '0;
      walk       <= LED_ONE;
      dir        <= UP;
      lvl        <= 4'd0;
      lvl_dir    <= UP;
      led_output <= LEDS_OFF;
    end else begin
      mode_q     <= mode_q_n;
      cnt        <= cnt_n;
      walk       <= walk_n;
      dir        <= dir_n;
      lvl        <= lvl_n;
      lvl_dir    <= lvl_dir_n;
      led_output <= ACTIVE_LOW ? ~pattern : pattern;
      if (enable) begin
        pwm_cnt <= pwm_cnt + PWM_ONE;
        if (prescaler == PRE_LAST) begin
          prescaler <= '0;
          tick_out  <= 1'b1;
        end else begin
          prescaler <= prescaler + PRE_ONE;
          tick_out  <= 1'b0;
        end
      end else begin
        tick_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed bench with step-count reference model for led_pattern_gen
module tb_led_pattern_gen;

  localparam int CMAX = 9;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode   = 2'd0;
  logic       tick_out;
  logic [5:0] led_output;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LEDS(6), .CLK_HZ(10), .TICK_HZ(1), .ACTIVE_LOW(1'b1), .PWM_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .tick_out(tick_out), .led_output(led_output)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Raw (active-high) pattern after k advances since the current mode was entered.
  function automatic logic [5:0] pat(input logic [1:0] md, input int k, input int pwm);
    int p;
    int lvl;
    case (md)
      2'd0: return 6'(k % 64);
      2'd1: begin
        p = k % 10;
        if (p > 5) p = 10 - p;
        return 6'(1 << p);
      end
      2'd2: begin
        p = k % 64;
        return 6'(p ^ (p / 2));
      end
      default: begin
        p   = k % 30;
        lvl = (p <= 15) ? p : 30 - p;
        return (pwm < lvl) ? 6'h3F : 6'h00;
      end
    endcase
  endfunction

  bit         m_valid = 1'b0;
  int         m_pre, m_k, m_pwm;
  logic       m_tick;
  logic [1:0] m_modeq;
  logic [5:0] m_led;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b1;
      m_pre   <= 0;
      m_tick  <= 1'b0;
      m_modeq <= 2'd0;
      m_k     <= 0;
      m_pwm   <= 0;
      m_led   <= 6'h3F;
    end else begin
      m_led <= ~pat(m_modeq, m_k, m_pwm);
      if (enable) begin
        if (m_tick) begin
          if (mode != m_modeq) begin
            m_modeq <= mode;
            m_k     <= 0;
          end else begin
            m_k <= m_k + 1;
          end
        end
        m_tick <= (m_pre == CMAX);
        m_pre  <= (m_pre == CMAX) ? 0 : m_pre + 1;
        m_pwm  <= (m_pwm + 1) % 16;
      end else begin
        m_tick <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_tick", tick_out, m_tick);
      chk("model_led", led_output, m_led);
    end
  end

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    mode   = m;
    repeat (3) @(negedge clk);
    chk("reset_led", led_output, 6'h3F);
    chk("reset_tick", tick_out, 1'b0);
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  // Returns two clocks after the n-th tick pulse, once the step is visible on led_output.
  task automatic wait_steps(input int n);
    int w;
    for (int s = 0; s < n; s++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (tick_out !== 1'b1 && w < 40);
      if (w >= 40) chk("tick_timeout", tick_out, 1'b1);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [5:0] walk_seq [11] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01, 6'h02};
  logic [5:0] gray_seq [4]  = '{6'h01, 6'h03, 6'h02, 6'h06};

  initial begin
    logic [5:0] e;
    int n_dark;

    do_reset(2'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("tick_period", tick_out, (i % 10 == 0));
    end

    do_reset(2'd0);
    wait_steps(3);
    chk("binary_3", led_output, 6'b111100);
    wait_steps(61);
    chk("binary_wrap", led_output, 6'h3F);

    do_reset(2'd1);
    wait_steps(1);
    chk("walk_init", led_output, 6'h3E);
    for (int i = 0; i < 11; i++) begin
      wait_steps(1);
      e = ~walk_seq[i];
      chk("walk_step", led_output, e);
    end

    do_reset(2'd0);
    wait_steps(5);
    chk("binary_5", led_output, 6'h3A);
    mode = 2'd2;
    wait_steps(1);
    chk("gray_reinit", led_output, 6'h3F);
    for (int i = 0; i < 4; i++) begin
      wait_steps(1);
      e = ~gray_seq[i];
      chk("gray_step", led_output, e);
    end

    do_reset(2'd3);
    wait_steps(1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("breathe_lvl0_dark", led_output, 6'h3F);
    end
    wait_steps(4);
    n_dark = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (led_output == 6'h00) n_dark++;
      chk("breathe_lvl5", led_output, (i >= 3 && i <= 7) ? 6'h00 : 6'h3F);
    end
    chk("breathe_lit_count", n_dark, 5);
    wait_steps(14);

    do_reset(2'd1);
    wait_steps(3);
    chk("walk_before_freeze", led_output, 6'h3B);
    enable = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("frozen_tick", tick_out, 1'b0);
      chk("frozen_led", led_output, 6'h3B);
    end
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_led", led_output, 6'h3F);
    chk("midrun_reset_tick", tick_out, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("restart_tick", tick_out, (i == 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1);
  end

endmodule
